// File: rtl/systolic_skew_feeder_if.sv
// Beat bus into the skew feeder and the skewed edge bus out to the systolic array.
// master = upstream/array side, slave = feeder side.
interface systolic_skew_feeder_if #(
    parameter int unsigned PE_ROWS      = 4,
    parameter int unsigned PE_COLS      = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [PE_ROWS*DATA_WIDTH-1:0]      act_vec;
    logic [PE_COLS*WEIGHT_WIDTH-1:0]    wgt_vec;
    logic [PE_ROWS*DATA_WIDTH-1:0]      act_out;
    logic [PE_ROWS-1:0]                 act_valid_out;
    logic [PE_COLS*WEIGHT_WIDTH-1:0]    wgt_out;
    logic [PE_COLS-1:0]                 wgt_valid_out;

    modport master (
        output in_valid, act_vec, wgt_vec,
        input  in_ready, act_out, act_valid_out, wgt_out, wgt_valid_out
    );

    modport slave (
        input  in_valid, act_vec, wgt_vec,
        output in_ready, act_out, act_valid_out, wgt_out, wgt_valid_out
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds K-step beats into the systolic array with per-lane diagonal skew and
// sequences each tile through clear, stream, flush and done.
module systolic_skew_feeder #(
    parameter int unsigned PE_ROWS      = 4,
    parameter int unsigned PE_COLS      = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned K_WIDTH      = 8,
    parameter int unsigned PE_LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    systolic_skew_feeder_if.slave        bus,
    output logic                         clear_accum,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned FLUSH_CYC = (PE_ROWS - 1) + (PE_COLS - 1) + PE_LATENCY;
    localparam int unsigned FLUSH_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   k_len_q, k_len_d;
    logic [K_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 clear_accum_q, clear_accum_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;

    assign accept = bus.in_valid & in_ready_q;

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d    = k_len;
                    beat_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                flush_cnt_d = '0;
                state_d     = (k_len_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                if (accept) begin
                    if (beat_cnt_q + K_WIDTH'(1) == k_len_q) begin
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d    = (state_d == STREAM);
        clear_accum_d = (state_d == CLEAR);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_len_q       <= '0;
            beat_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            in_ready_q    <= 1'b0;
            clear_accum_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_len_q       <= k_len_d;
            beat_cnt_q    <= beat_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            in_ready_q    <= in_ready_d;
            clear_accum_q <= clear_accum_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign clear_accum  = clear_accum_q;
    assign busy         = busy_q;
    assign done         = done_q;

    logic [PE_ROWS*DATA_WIDTH-1:0]   act_out_w;
    logic [PE_ROWS-1:0]              act_valid_w;
    logic [PE_COLS*WEIGHT_WIDTH-1:0] wgt_out_w;
    logic [PE_COLS-1:0]              wgt_valid_w;

    // Activation row r: r+1 stage shift line, last stage is the lane output register.
    for (genvar r = 0; r < PE_ROWS; r++) begin : g_act
        logic [r:0][DATA_WIDTH-1:0] act_pipe_q, act_pipe_d;
        logic [r:0]                 act_vld_q, act_vld_d;

        always_comb begin
            act_pipe_d[0] = accept ? bus.act_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            act_vld_d[0]  = accept;
            for (int i = 1; i <= r; i++) begin
                act_pipe_d[i] = act_pipe_q[i-1];
                act_vld_d[i]  = act_vld_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_pipe_q <= '0;
                act_vld_q  <= '0;
            end else begin
                act_pipe_q <= act_pipe_d;
                act_vld_q  <= act_vld_d;
            end
        end

        assign act_out_w[r*DATA_WIDTH +: DATA_WIDTH] = act_pipe_q[r];
        assign act_valid_w[r]                        = act_vld_q[r];
    end

    // Weight column c: c+1 stage shift line, same structure as the activation rows.
    for (genvar c = 0; c < PE_COLS; c++) begin : g_wgt
        logic [c:0][WEIGHT_WIDTH-1:0] wgt_pipe_q, wgt_pipe_d;
        logic [c:0]                   wgt_vld_q, wgt_vld_d;

        always_comb begin
            wgt_pipe_d[0] = accept ? bus.wgt_vec[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
            wgt_vld_d[0]  = accept;
            for (int i = 1; i <= c; i++) begin
                wgt_pipe_d[i] = wgt_pipe_q[i-1];
                wgt_vld_d[i]  = wgt_vld_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wgt_pipe_q <= '0;
                wgt_vld_q  <= '0;
            end else begin
                wgt_pipe_q <= wgt_pipe_d;
                wgt_vld_q  <= wgt_vld_d;
            end
        end

        assign wgt_out_w[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wgt_pipe_q[c];
        assign wgt_valid_w[c]                            = wgt_vld_q[c];
    end

    assign bus.act_out       = act_out_w;
    assign bus.act_valid_out = act_valid_w;
    assign bus.wgt_out       = wgt_out_w;
    assign bus.wgt_valid_out = wgt_valid_w;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: tile timing, skew, bubbles, k_len=0,
// ignored start, asynchronous reset mid-tile.
module tb_systolic_skew_feeder;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned WW   = 8;
    localparam int unsigned KW   = 8;
    localparam int          MAXC = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          clear_accum;
    logic          busy;
    logic          done;

    systolic_skew_feeder_if #(
        .PE_ROWS(ROWS), .PE_COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)
    ) bus_if ();

    systolic_skew_feeder #(
        .PE_ROWS(ROWS), .PE_COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .K_WIDTH(KW), .PE_LATENCY(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .bus         (bus_if),
        .clear_accum (clear_accum),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic          rec_clear [MAXC];
    logic          rec_ready [MAXC];
    logic          rec_busy  [MAXC];
    logic          rec_done  [MAXC];
    logic [ROWS-1:0] rec_av  [MAXC];
    logic [COLS-1:0] rec_wv  [MAXC];
    logic [DW-1:0] rec_act [MAXC][ROWS];
    logic [WW-1:0] rec_wgt [MAXC][COLS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs ncyc cycles starting just after a posedge (cycle 0) and records outputs mid-cycle.
    task automatic run(input int ncyc, input int k, input logic [MAXC-1:0] vmask,
                       input logic [MAXC-1:0] smask);
        int b;
        b = 0;
        for (int c = 0; c < ncyc; c++) begin
            start           = smask[c];
            k_len           = KW'(k);
            bus_if.in_valid = vmask[c];
            for (int r = 0; r < int'(ROWS); r++)
                bus_if.act_vec[r*DW +: DW] = DW'(32'h100 * (b + 1) + r);
            for (int cc = 0; cc < int'(COLS); cc++)
                bus_if.wgt_vec[cc*WW +: WW] = WW'(32'h10 * (b + 1) + cc);
            @(negedge clk);
            rec_clear[c] = clear_accum;
            rec_ready[c] = bus_if.in_ready;
            rec_busy[c]  = busy;
            rec_done[c]  = done;
            rec_av[c]    = bus_if.act_valid_out;
            rec_wv[c]    = bus_if.wgt_valid_out;
            for (int r = 0; r < int'(ROWS); r++)
                rec_act[c][r] = bus_if.act_out[r*DW +: DW];
            for (int cc = 0; cc < int'(COLS); cc++)
                rec_wgt[c][cc] = bus_if.wgt_out[cc*WW +: WW];
            if (bus_if.in_valid && bus_if.in_ready) b++;
            @(posedge clk);
            #1;
        end
        start           = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    // Compares recorded cycles against hand-derived windows and accept cycles a0..a2.
    task automatic check_run(input string nm, input int ncyc, input int clr_c,
                             input int rdy_lo, input int rdy_hi, input int done_c,
                             input int a0, input int a1, input int a2, input int nacc);
        int acc [3];
        logic          ev;
        logic [DW-1:0] ed;
        logic [WW-1:0] ew;
        acc[0] = a0; acc[1] = a1; acc[2] = a2;
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("%s clear c%0d", nm, c), 32'(rec_clear[c]), 32'(c == clr_c));
            check($sformatf("%s ready c%0d", nm, c), 32'(rec_ready[c]), 32'(c >= rdy_lo && c <= rdy_hi));
            check($sformatf("%s done c%0d", nm, c),  32'(rec_done[c]),  32'(c == done_c));
            check($sformatf("%s busy c%0d", nm, c),  32'(rec_busy[c]),  32'(c >= 1 && c <= done_c));
            for (int r = 0; r < int'(ROWS); r++) begin
                ev = 1'b0; ed = '0;
                for (int j = 0; j < nacc; j++)
                    if (acc[j] + 1 + r == c) begin
                        ev = 1'b1; ed = DW'(32'h100 * (j + 1) + r);
                    end
                check($sformatf("%s av%0d c%0d", nm, r, c), 32'(rec_av[c][r]), 32'(ev));
                check($sformatf("%s ad%0d c%0d", nm, r, c), 32'(rec_act[c][r]), 32'(ed));
            end
            for (int cc = 0; cc < int'(COLS); cc++) begin
                ev = 1'b0; ew = '0;
                for (int j = 0; j < nacc; j++)
                    if (acc[j] + 1 + cc == c) begin
                        ev = 1'b1; ew = WW'(32'h10 * (j + 1) + cc);
                    end
                check($sformatf("%s wv%0d c%0d", nm, cc, c), 32'(rec_wv[c][cc]), 32'(ev));
                check($sformatf("%s wd%0d c%0d", nm, cc, c), 32'(rec_wgt[c][cc]), 32'(ew));
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " in_ready"},  32'(bus_if.in_ready),      32'h0);
        check({nm, " busy"},      32'(busy),                 32'h0);
        check({nm, " done"},      32'(done),                 32'h0);
        check({nm, " clear"},     32'(clear_accum),          32'h0);
        check({nm, " act_valid"}, 32'(bus_if.act_valid_out), 32'h0);
        check({nm, " wgt_valid"}, 32'(bus_if.wgt_valid_out), 32'h0);
        check({nm, " act_out"},   32'(bus_if.act_out[31:0]), 32'h0);
        check({nm, " act_hi"},    32'(bus_if.act_out[63:32]), 32'h0);
        check({nm, " wgt_out"},   32'(bus_if.wgt_out),       32'h0);
    endtask

    logic [MAXC-1:0] all1;
    logic [MAXC-1:0] gap;
    logic [MAXC-1:0] smask;

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        k_len           = '0;
        bus_if.in_valid = 1'b0;
        bus_if.act_vec  = '0;
        bus_if.wgt_vec  = '0;
        all1            = '1;
        gap             = '1;
        gap[3]          = 1'b0;
        smask           = '0;

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal tile; in_valid also held high in IDLE and FLUSH.
        run(16, 3, all1, 32'h1);
        check_run("nominal", 16, 1, 2, 4, 12, 2, 3, 4, 3);

        // One-cycle upstream bubble in cycle 3.
        run(17, 3, gap, 32'h1);
        check_run("bubble", 17, 1, 2, 5, 13, 2, 4, 5, 3);

        // Empty tile.
        run(6, 0, all1, 32'h1);
        check_run("k0", 6, 1, 1, 0, 2, 0, 0, 0, 0);

        // start re-pulsed mid-tile must be ignored.
        smask[0] = 1'b1; smask[4] = 1'b1; smask[8] = 1'b1;
        run(20, 3, all1, smask);
        check_run("restart", 20, 1, 2, 4, 12, 2, 3, 4, 3);

        // Asynchronous reset in cycle 3 of a tile.
        run(3, 3, all1, 32'h1);
        bus_if.in_valid = 1'b1;
        #2;
        check("pre-reset busy",      32'(busy),                 32'h1);
        check("pre-reset act_valid", 32'(bus_if.act_valid_out), 32'h1);
        check("pre-reset act0",      32'(bus_if.act_out[15:0]), 32'h0100);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("held reset");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(16, 3, all1, 32'h1);
        check_run("post-reset", 16, 1, 2, 4, 12, 2, 3, 4, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
